// File: rtl/axis_capture_pkg.sv
// Shared constants for the triggered AXI4-Stream capture sequencer:
// state encoding used on the status port and by the controller FSM.
package axis_capture_pkg;

   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
   localparam logic [STATE_W-1:0] ST_ARMED   = 2'd1;
   localparam logic [STATE_W-1:0] ST_CAPTURE = 2'd2;
   localparam logic [STATE_W-1:0] ST_DONE    = 2'd3;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE    = ST_IDLE,
      S_ARMED   = ST_ARMED,
      S_CAPTURE = ST_CAPTURE,
      S_DONE    = ST_DONE
   } state_e;

endpackage

// File: rtl/axis_capture_ctrl_if.sv
// Upstream and downstream stream signals of the capture controller.
// master = the controller view, slave = the source/DMA environment view.
interface axis_capture_ctrl_if #(
   parameter int TDATA_WIDTH = 32
);
   logic                     s_axis_tvalid;
   logic                     s_axis_tready;
   logic [TDATA_WIDTH-1:0]   s_axis_tdata;
   logic                     m_axis_tvalid;
   logic                     m_axis_tready;
   logic [TDATA_WIDTH-1:0]   m_axis_tdata;
   logic                     m_axis_tlast;
   logic [TDATA_WIDTH/8-1:0] m_axis_tkeep;

   modport master (
      input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
      output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tkeep
   );

   modport slave (
      output s_axis_tvalid, s_axis_tdata, m_axis_tready,
      input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tkeep
   );
endinterface

// File: rtl/axis_pkt_counter.sv
// Beat counter within a packet: drives TLAST on beat len-1 and strobes
// packet completion when that last beat is accepted.
module axis_pkt_counter #(
   parameter int LEN_WIDTH = 24
) (
   input  logic                 aclk,
   input  logic                 resetn,
   input  logic                 clr_i,
   input  logic                 active_i,
   input  logic                 beat_i,
   input  logic [LEN_WIDTH-1:0] len_i,
   output logic [LEN_WIDTH-1:0] beat_cnt_o,
   output logic                 tlast_o,
   output logic                 pkt_done_o
);

   logic [LEN_WIDTH-1:0] beat_cnt_q;
   logic [LEN_WIDTH-1:0] beat_cnt_d;

   // Beat counter register.
   always_ff @(posedge aclk) begin
      if (!resetn) begin
         beat_cnt_q <= '0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // TLAST compare and next count; len_i==1 makes every beat a last beat.
   always_comb begin
      tlast_o    = active_i && (beat_cnt_q == (len_i - LEN_WIDTH'(1)));
      pkt_done_o = beat_i && tlast_o;
      beat_cnt_d = beat_cnt_q;
      if (clr_i) begin
         beat_cnt_d = '0;
      end else if (pkt_done_o) begin
         beat_cnt_d = '0;
      end else if (beat_i) begin
         beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
      end else begin
         beat_cnt_d = beat_cnt_q;
      end
   end

   assign beat_cnt_o = beat_cnt_q;

endmodule

// File: rtl/axis_capture_ctrl.sv
// Triggered AXI4-Stream capture sequencer: arm/trigger FSM, trigger edge
// detection and whole-packet gating of the stream towards the DMA.
module axis_capture_ctrl
   import axis_capture_pkg::*;
#(
   parameter int TDATA_WIDTH = 32,
   parameter int LEN_WIDTH   = 24,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 aclk,
   input  logic                 resetn,
   input  logic [LEN_WIDTH-1:0] cfg_pkt_len,
   input  logic [CNT_WIDTH-1:0] cfg_n_pkts,
   input  logic                 arm,
   input  logic                 abort,
   input  logic                 trig,
   input  logic                 sw_trig,
   axis_capture_ctrl_if.master  bus,
   output logic [STATE_W-1:0]   state,
   output logic                 done_pulse,
   output logic                 cfg_err,
   output logic [CNT_WIDTH-1:0] pkt_count
);

   state_e               state_q, state_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic [CNT_WIDTH-1:0] npk_q, npk_d;
   logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
   logic                 stop_req_q, stop_req_d;
   logic                 cfg_err_q, cfg_err_d;
   logic                 done_pulse_q, done_pulse_d;
   logic                 trig_d_q;

   logic                 capture;
   logic                 beat;
   logic                 trg;
   logic                 cnt_clr;
   logic                 tlast;
   logic                 pkt_done;
   logic [LEN_WIDTH-1:0] beat_cnt;
   logic [CNT_WIDTH-1:0] pkt_inc;

   assign capture = (state_q == S_CAPTURE);
   assign beat    = capture && bus.s_axis_tvalid && bus.m_axis_tready;
   assign trg     = (trig && !trig_d_q) || sw_trig;
   assign pkt_inc = pkt_count_q + CNT_WIDTH'(1);

   axis_pkt_counter #(
      .LEN_WIDTH (LEN_WIDTH)
   ) u_cnt (
      .aclk       (aclk),
      .resetn     (resetn),
      .clr_i      (cnt_clr),
      .active_i   (capture),
      .beat_i     (beat),
      .len_i      (len_q),
      .beat_cnt_o (beat_cnt),
      .tlast_o    (tlast),
      .pkt_done_o (pkt_done)
   );

   // Control and status registers.
   always_ff @(posedge aclk) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         len_q        <= '0;
         npk_q        <= '0;
         pkt_count_q  <= '0;
         stop_req_q   <= 1'b0;
         cfg_err_q    <= 1'b0;
         done_pulse_q <= 1'b0;
         trig_d_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         npk_q        <= npk_d;
         pkt_count_q  <= pkt_count_d;
         stop_req_q   <= stop_req_d;
         cfg_err_q    <= cfg_err_d;
         done_pulse_q <= done_pulse_d;
         trig_d_q     <= trig;
      end
   end

   // Next-state logic; abort is only honoured on a packet boundary.
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      npk_d        = npk_q;
      pkt_count_d  = pkt_count_q;
      stop_req_d   = stop_req_q;
      cfg_err_d    = cfg_err_q;
      done_pulse_d = 1'b0;
      cnt_clr      = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (arm && (cfg_pkt_len != '0)) begin
               len_d       = cfg_pkt_len;
               npk_d       = cfg_n_pkts;
               pkt_count_d = '0;
               stop_req_d  = 1'b0;
               cfg_err_d   = 1'b0;
               cnt_clr     = 1'b1;
               state_d     = S_ARMED;
            end else if (arm) begin
               cfg_err_d = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         S_ARMED: begin
            if (abort) begin
               state_d      = S_IDLE;
               done_pulse_d = 1'b1;
            end else if (trg) begin
               state_d = S_CAPTURE;
            end else begin
               state_d = S_ARMED;
            end
         end
         S_CAPTURE: begin
            if (pkt_done) begin
               pkt_count_d = pkt_inc;
               if ((npk_q != '0) && (pkt_inc == npk_q)) begin
                  state_d      = S_DONE;
                  done_pulse_d = 1'b1;
               end else if (stop_req_q || abort) begin
                  state_d      = S_IDLE;
                  done_pulse_d = 1'b1;
               end else begin
                  state_d = S_CAPTURE;
               end
            end else if (abort && (beat_cnt == '0) && !beat) begin
               state_d      = S_IDLE;
               done_pulse_d = 1'b1;
            end else if (abort) begin
               stop_req_d = 1'b1;
            end else begin
               state_d = S_CAPTURE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Stream gating: outside CAPTURE the source is drained and nothing is sent.
   always_comb begin
      bus.m_axis_tdata = bus.s_axis_tdata;
      if (capture) begin
         bus.m_axis_tvalid = bus.s_axis_tvalid;
         bus.s_axis_tready = bus.m_axis_tready;
      end else begin
         bus.m_axis_tvalid = 1'b0;
         bus.s_axis_tready = 1'b1;
      end
   end

   assign bus.m_axis_tlast = tlast;
   assign bus.m_axis_tkeep = {(TDATA_WIDTH/8){1'b1}};
   assign state            = state_q;
   assign done_pulse       = done_pulse_q;
   assign cfg_err          = cfg_err_q;
   assign pkt_count        = pkt_count_q;

endmodule
